// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master sequencer: state encoding, R/W bit values
// and default START/STOP hold lengths.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_DATA     = 4'd4,
        ST_DATA_RD  = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_STOP     = 4'd7,
        ST_DONE     = 4'd8
    } i2c_state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    localparam int unsigned DEFAULT_START_HOLD = 4;
    localparam int unsigned DEFAULT_STOP_HOLD  = 4;

    // Terminal value of an 8-bit hold counter that starts at zero.
    function automatic logic [7:0] hold_last(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/i2c_edge_detect.sv
// Registers an SCL-rate square wave once and emits single-cycle rise/fall pulses.
// Idle level is high, so leaving reset never produces a spurious edge.
module i2c_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    output logic rise_o,
    output logic fall_o
);

    logic scl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
        end
    end

    assign rise_o = ~scl_q & scl_i;
    assign fall_o = scl_q & ~scl_i;

endmodule

// File: rtl/i2c_write_sequencer.sv
// I2C master that runs one START/address/ACK/data/ACK/STOP write around the baud generator.
// Define I2C_READ_EN to add a single-byte read (RW input, DataOut output, DATA_RD state).
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned StartHoldCycles = DEFAULT_START_HOLD,
    parameter int unsigned StopHoldCycles  = DEFAULT_STOP_HOLD
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Go,
    input  logic [6:0] SlaveAddress,
    input  logic [7:0] DataIn,
    input  logic       ClockI2C,
    input  logic       SDAIn,
`ifdef I2C_READ_EN
    input  logic       RW,
    output logic [7:0] DataOut,
`endif
    output logic       BaudEnable,
    output logic       SCL,
    output logic       SDAOut,
    output logic       SDAOE,
    output logic       Busy,
    output logic       Done,
    output logic       AckError
);

    localparam logic [7:0] START_LAST = hold_last(StartHoldCycles);
    localparam logic [7:0] STOP_LAST  = hold_last(StopHoldCycles);

    i2c_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       bit_last_q, bit_last_d;
    logic       sda_oe_q, sda_oe_d;
    logic       sda_out_q, sda_out_d;
    logic       baud_en_q, baud_en_d;
    logic       ack_err_q, ack_err_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       scl_rise, scl_fall;

`ifdef I2C_READ_EN
    logic       rw_q, rw_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] dout_q, dout_d;
`endif

    i2c_edge_detect u_edge (
        .clk_i  (clock),
        .rst_ni (Reset),
        .scl_i  (ClockI2C),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    // State and control registers
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            bit_cnt_q  <= 3'd0;
            bit_last_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            sda_out_q  <= 1'b1;
            baud_en_q  <= 1'b0;
            ack_err_q  <= 1'b0;
`ifdef I2C_READ_EN
            rw_q       <= I2C_WRITE;
            dout_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_last_q <= bit_last_d;
            sda_oe_q   <= sda_oe_d;
            sda_out_q  <= sda_out_d;
            baud_en_q  <= baud_en_d;
            ack_err_q  <= ack_err_d;
`ifdef I2C_READ_EN
            rw_q       <= rw_d;
            dout_q     <= dout_d;
`endif
        end
    end

    // Shift registers carry payload only; their contents are always loaded before use.
    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
`ifdef I2C_READ_EN
        rd_q   <= rd_d;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bit_last_d = bit_last_q;
        sda_oe_d   = sda_oe_q;
        sda_out_d  = sda_out_q;
        baud_en_d  = baud_en_q;
        ack_err_d  = ack_err_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef I2C_READ_EN
        rw_d       = rw_q;
        rd_d       = rd_q;
        dout_d     = dout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Go) begin
`ifdef I2C_READ_EN
                    rw_d   = RW ? I2C_READ : I2C_WRITE;
                    addr_d = {SlaveAddress, RW ? I2C_READ : I2C_WRITE};
`else
                    addr_d = {SlaveAddress, I2C_WRITE};
`endif
                    data_d     = DataIn;
                    ack_err_d  = 1'b0;
                    cnt_d      = 8'd0;
                    sda_oe_d   = 1'b1;
                    sda_out_d  = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d      = 8'd0;
                    bit_cnt_d  = 3'd0;
                    bit_last_d = 1'b0;
                    baud_en_d  = 1'b1;
                    state_d    = ST_ADDR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ADDR: begin
                if (scl_fall) begin
                    if (bit_last_q) begin
                        bit_cnt_d  = 3'd0;
                        bit_last_d = 1'b0;
                        sda_oe_d   = 1'b0;
                        sda_out_d  = 1'b1;
                        state_d    = ST_ADDR_ACK;
                    end else begin
                        sda_out_d  = addr_q[7];
                        addr_d     = {addr_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        bit_last_d = (bit_cnt_q == 3'd7);
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (scl_rise && SDAIn) begin
                    ack_err_d = 1'b1;
                end
                // The ACK slot ends on the fall; the first data bit goes out on that same fall.
                if (scl_fall) begin
                    if (ack_err_q) begin
                        sda_oe_d  = 1'b1;
                        sda_out_d = 1'b0;
                        cnt_d     = 8'd0;
                        state_d   = ST_STOP;
`ifdef I2C_READ_EN
                    end else if (rw_q) begin
                        bit_cnt_d  = 3'd0;
                        bit_last_d = 1'b0;
                        state_d    = ST_DATA_RD;
`endif
                    end else begin
                        sda_oe_d   = 1'b1;
                        sda_out_d  = data_q[7];
                        data_d     = {data_q[6:0], 1'b0};
                        bit_cnt_d  = 3'd1;
                        bit_last_d = 1'b0;
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (scl_fall) begin
                    if (bit_last_q) begin
                        bit_cnt_d  = 3'd0;
                        bit_last_d = 1'b0;
                        sda_oe_d   = 1'b0;
                        sda_out_d  = 1'b1;
                        state_d    = ST_DATA_ACK;
                    end else begin
                        sda_out_d  = data_q[7];
                        data_d     = {data_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        bit_last_d = (bit_cnt_q == 3'd7);
                    end
                end
            end
`ifdef I2C_READ_EN
            ST_DATA_RD: begin
                if (scl_rise && !bit_last_q) begin
                    rd_d       = {rd_q[6:0], SDAIn};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    bit_last_d = (bit_cnt_q == 3'd7);
                end
                // Master NACK is sent by leaving SDA released through the ACK slot.
                if (scl_fall && bit_last_q) begin
                    bit_cnt_d  = 3'd0;
                    bit_last_d = 1'b0;
                    sda_oe_d   = 1'b0;
                    sda_out_d  = 1'b1;
                    state_d    = ST_DATA_ACK;
                end
            end
`endif
            ST_DATA_ACK: begin
`ifdef I2C_READ_EN
                if (scl_rise && SDAIn && !rw_q) begin
                    ack_err_d = 1'b1;
                end
`else
                if (scl_rise && SDAIn) begin
                    ack_err_d = 1'b1;
                end
`endif
                if (scl_fall) begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // One cycle with SCL still low, then park SCL high and time the STOP setup.
                if (baud_en_q) begin
                    baud_en_d = 1'b0;
                    cnt_d     = 8'd0;
                end else if (cnt_q == STOP_LAST) begin
                    sda_oe_d  = 1'b0;
                    sda_out_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_DONE;
`ifdef I2C_READ_EN
                    dout_d    = rd_q;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        BaudEnable = baud_en_q;
        SCL        = baud_en_q ? ClockI2C : 1'b1;
        SDAOut     = sda_out_q;
        SDAOE      = sda_oe_q;
        Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        Done       = (state_q == ST_DONE);
        AckError   = ack_err_q;
`ifdef I2C_READ_EN
        DataOut    = dout_q;
`endif
    end

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Master-side controller that sequences one I2C write transaction (START, 7-bit address + R/W, ACK, 8-bit data, ACK, STOP) around the I2C_BaudRateGenerator.
- Gates the generator via BaudEnable and uses its ClockI2C output as the SCL timebase.
- Shifts SDA on SCL falling edges and samples ACK on SCL rising edges.
- Sits between a host register interface and the open-drain SDA/SCL pad logic.

Parameters:
- StartHoldCycles, 4, clock cycles SDA is held low with SCL high before BaudEnable asserts (START hold); 8-bit counter, legal 1..255.
- StopHoldCycles, 4, clock cycles SCL is high with SDA low before SDA is released (STOP setup); legal 1..255.

Ports:
- clock  input  1  system clock; sole clock.
- Reset  input  1  asynchronous, active-low reset.
- Go  input  1  one-cycle transaction request; sampled only in IDLE.
- SlaveAddress  input  7  target address; latched on accepted Go.
- DataIn  input  8  write byte; latched on accepted Go.
- ClockI2C  input  1  SCL square wave from I2C_BaudRateGenerator (same clock domain).
- BaudEnable  output  1  Enable to I2C_BaudRateGenerator.
- SCL  output  1  ClockI2C when BaudEnable=1, else 1.
- SDAOut  output  1  SDA drive value (0 only meaningful when SDAOE=1).
- SDAOE  output  1  1 = pull SDA low/drive; 0 = release (bus pull-up).
- SDAIn  input  1  sampled SDA line.
- Busy  output  1  high from accepted Go until Done.
- Done  output  1  one-cycle pulse at end of transaction.
- AckError  output  1  sticky NACK flag for the last transaction; cleared on accepted Go.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, BaudEnable=0, SDAOE=0, SDAOut=1, Busy=0, Done=0, AckError=0, counters 0.
- Edge detect: ClockI2C registered once; fall = prev 1 and now 0; rise = prev 0 and now 1. Edges are acted on one cycle after ClockI2C changes.
- IDLE: SDA released, SCL=1.
  - Go=1: latch shift register {SlaveAddress, 1'b0} and DataIn, clear AckError, Busy=1, go to START.
- START:
  - SDAOE=1, SDAOut=0.
  - Count StartHoldCycles, then BaudEnable=1 and go to ADDR.
- ADDR:
  - On each fall, drive the next shift bit, MSB first.
  - After 8 bits are driven, the next fall moves to ADDR_ACK.
- ADDR_ACK:
  - SDA released on entry.
  - Sample SDAIn on rise: 0 -> on next fall go to DATA; 1 -> AckError=1, on next fall go to STOP.
- DATA: same as ADDR with the data byte; then DATA_ACK.
- DATA_ACK:
  - SDA released on entry.
  - Sample on rise; NACK sets AckError.
  - Next fall -> STOP.
- STOP:
  - On entry SDAOE=1, SDAOut=0.
  - Hold one clock, then BaudEnable=0 so SCL=1.
  - Count StopHoldCycles, then release SDA and go to DONE.
- DONE: Done=1 for one cycle, Busy=0, go to IDLE.
- Go outside IDLE: ignored, no queuing.
- Reset mid-transaction: immediate return to reset values; no STOP is generated.
- Bit counter: 3-bit plus terminal flag; no wrap beyond 8 bits per byte.

Optional Feature:
- Macro I2C_READ_EN.
- Defined:
  - Adds input RW and output DataOut[7:0], reset 0.
  - RW=1 sends R/W bit 1. After address ACK, state DATA_RD releases SDA and shifts SDAIn on 8 rises, MSB first.
  - Master drives NACK (SDA=1 via release) in DATA_ACK, then STOP. DataOut is updated at DONE.
- Undefined: R/W bit is constant 0; ports absent; DATA_RD state is not compiled.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_RD, DATA_ACK, STOP, DONE).
  - I2C_WRITE=0 and I2C_READ=1.
  - Default hold cycle constants.
- Sub-module i2c_edge_detect (register ClockI2C, emit rise and fall pulses). Natural and reusable by a future slave block.

Test Plan:
- Bench drives ClockI2C toggling every 5 clocks while BaudEnable=1, held 1 otherwise.
- Write, SlaveAddress=7'h50, DataIn=8'hA5, SDAIn=0 at both ACKs:
  - SDA bits at SCL rises are 1010000 0, ACK, 10100101, ACK.
  - START and STOP hold of 4 clocks each.
  - Done pulses once; AckError=0.
- Address NACK, SDAIn=1 during ADDR_ACK:
  - No data bits are driven; STOP follows.
  - AckError=1; Done pulses.
- Data NACK only: all 8 data bits are sent, then AckError=1 and a normal STOP.
- Go pulsed again mid-DATA with SlaveAddress=7'h11: ignored; the transaction completes with 7'h50; a Go after Done starts 7'h11.
- Reset=0 asserted during DATA bit 3:
  - Outputs are at reset values within the same cycle (asynchronous).
  - A later Go runs cleanly.
- With I2C_READ_EN, RW=1, slave returns 8'h3C: R/W bit=1, DataOut=8'h3C at Done, master NACK observed.
